// File: rtl/prefix_cpa_pipe.sv
// Pipelined Kogge-Stone carry-propagate adder over 2-bit KPG codes (00 kill, 11 generate, 01/10 propagate).
// Register slices sit after every LEVELS_PER_STAGE prefix levels; a global stall freezes all stages.
module prefix_cpa_pipe #(
  parameter int WIDTH            = 64,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG_W = $clog2(WIDTH);
  localparam int K     = (LOG_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Index 0 holds the carry-in code; index i+1 holds operand bit i.
  typedef logic [WIDTH:0][1:0] kpg_row_t;

  function automatic logic [1:0] kpg_op(input logic [1:0] hi, input logic [1:0] lo);
    return (hi == 2'b00 || hi == 2'b11) ? hi : lo;
  endfunction

  function automatic kpg_row_t prefix_levels(input kpg_row_t row, input int first);
    kpg_row_t cur;
    kpg_row_t nxt;
    cur = row;
    for (int m = 0; m < LEVELS_PER_STAGE; m++) begin
      nxt = cur;
      if (first + m < LOG_W) begin
        for (int p = 0; p <= WIDTH; p++) begin
          if (p >= (1 << (first + m)))
            nxt[p] = kpg_op(cur[p], cur[p - (1 << (first + m))]);
        end
      end
      cur = nxt;
    end
    return cur;
  endfunction

  kpg_row_t         code_q [0:K];
  kpg_row_t         code_d [1:K];
  logic [WIDTH-1:0] pxor_q [0:K];
  logic [TAG_W-1:0] tag_q  [0:K];
  logic [K:0]       vld_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic [TAG_W-1:0] out_tag_q;

  kpg_row_t         code_in;
  logic [WIDTH-1:0] sum_d;
  logic [1:0]       cout_code;
  logic             stall;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~rst & ~stall;

  always_comb begin
    code_in    = '0;
    code_in[0] = {in_cin, in_cin};
    for (int i = 0; i < WIDTH; i++) code_in[i+1] = {in_a[i], in_b[i]};
  end

  genvar gi;
  generate
    for (gi = 1; gi <= K; gi++) begin : g_stage
      assign code_d[gi] = prefix_levels(code_q[gi-1], (gi - 1) * LEVELS_PER_STAGE);
    end
  endgenerate

  // After the last slice, code at index i is the carry into bit i.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < WIDTH; i++) sum_d[i] = pxor_q[K][i] ^ code_q[K][i][1];
  end

  // The top position spans bits 0..WIDTH-1 only; fold in the carry-in code for the full prefix.
  assign cout_code = kpg_op(code_q[K][WIDTH], code_q[K][0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_tag_q   <= '0;
      for (int k = 0; k <= K; k++) begin
        code_q[k] <= '0;
        pxor_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (!stall) begin
      vld_q     <= {vld_q[K-1:0], in_valid};
      code_q[0] <= code_in;
      pxor_q[0] <= in_a ^ in_b;
      tag_q[0]  <= in_tag;
      for (int k = 1; k <= K; k++) begin
        code_q[k] <= code_d[k];
        pxor_q[k] <= pxor_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
      out_valid_q <= vld_q[K];
      if (vld_q[K]) begin
        out_sum_q  <= sum_d;
        out_cout_q <= cout_code[1];
        out_tag_q  <= tag_q[K];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_tag   = out_tag_q;

  // A complete prefix that still reads as propagate means the network is broken.
  a_cout_resolved: assert property (@(posedge clk) disable iff (rst)
    vld_q[K] |-> (cout_code == 2'b00 || cout_code == 2'b11));

endmodule

// File: tb/tb_prefix_cpa_pipe.sv
// Directed and streaming checks for prefix_cpa_pipe, plus a latency/parameter sweep on extra instances.
module tb_prefix_cpa_pipe;

  localparam int W   = 64;
  localparam int TW  = 8;
  localparam int LAT = 5;
  localparam int NSW = 12;
  localparam int NST = 20;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [7:0]  tag;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic          sw_valid;
  logic          sw_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic [TW-1:0] in_tag;

  wire           in_ready, out_valid, out_cout;
  wire [W-1:0]   out_sum;
  wire [TW-1:0]  out_tag;

  wire           l1_rdy, l1_valid, l1_cout;
  wire [W-1:0]   l1_sum;
  wire [TW-1:0]  l1_tag;
  wire           l3_rdy, l3_valid, l3_cout;
  wire [W-1:0]   l3_sum;
  wire [TW-1:0]  l3_tag;
  wire           l6_rdy, l6_valid, l6_cout;
  wire [W-1:0]   l6_sum;
  wire [TW-1:0]  l6_tag;
  wire           w16_rdy, w16_valid, w16_cout;
  wire [15:0]    w16_sum;
  wire [TW-1:0]  w16_tag;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [63:0] sw_a [NSW];
  logic [63:0] sw_b [NSW];
  logic        sw_cin [NSW];
  int          sw_acc [NSW];
  int          l1_idx = 0, l3_idx = 0, l6_idx = 0, w16_idx = 0;

  prefix_cpa_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_tag(out_tag));

  prefix_cpa_pipe #(.LEVELS_PER_STAGE(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(l1_rdy),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(l1_valid), .out_ready(sw_ready), .out_sum(l1_sum),
    .out_cout(l1_cout), .out_tag(l1_tag));

  prefix_cpa_pipe #(.LEVELS_PER_STAGE(3)) u_l3 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(l3_rdy),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(l3_valid), .out_ready(sw_ready), .out_sum(l3_sum),
    .out_cout(l3_cout), .out_tag(l3_tag));

  prefix_cpa_pipe #(.LEVELS_PER_STAGE(6)) u_l6 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(l6_rdy),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(l6_valid), .out_ready(sw_ready), .out_sum(l6_sum),
    .out_cout(l6_cout), .out_tag(l6_tag));

  prefix_cpa_pipe #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w16_rdy),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(w16_valid), .out_ready(sw_ready), .out_sum(w16_sum),
    .out_cout(w16_cout), .out_tag(w16_tag));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic sweep_check(input string name, input int idx, input int width, input int lat,
                             input logic [63:0] sum, input logic cout, input logic [7:0] tag);
    logic [64:0] full;
    logic [64:0] exp_sum;
    if (width == 64) begin
      full    = {1'b0, sw_a[idx]} + {1'b0, sw_b[idx]} + 65'(sw_cin[idx]);
      exp_sum = {1'b0, full[63:0]};
    end else begin
      full    = 65'({1'b0, sw_a[idx][15:0]} + {1'b0, sw_b[idx][15:0]} + 17'(sw_cin[idx]));
      exp_sum = 65'(full[15:0]);
    end
    check_eq({name, "_tag"}, 65'(tag), 65'(8'(idx)));
    check_eq({name, "_sum"}, 65'(sum), exp_sum);
    check_eq({name, "_cout"}, 65'(cout), 65'(full[width]));
    check_eq({name, "_lat"}, 65'(cyc - sw_acc[idx]), 65'(lat - 1));
    $display("sweep %s tag=%02h sum=%h cout=%0d", name, tag, sum, cout);
  endtask

  always @(negedge clk) if (l1_valid) begin
    if (l1_idx < NSW) sweep_check("l1", l1_idx, 64, 8, l1_sum, l1_cout, l1_tag);
    else check_eq("l1_extra", 65'(l1_idx), 65'(NSW - 1));
    l1_idx++;
  end
  always @(negedge clk) if (l3_valid) begin
    if (l3_idx < NSW) sweep_check("l3", l3_idx, 64, 4, l3_sum, l3_cout, l3_tag);
    else check_eq("l3_extra", 65'(l3_idx), 65'(NSW - 1));
    l3_idx++;
  end
  always @(negedge clk) if (l6_valid) begin
    if (l6_idx < NSW) sweep_check("l6", l6_idx, 64, 3, l6_sum, l6_cout, l6_tag);
    else check_eq("l6_extra", 65'(l6_idx), 65'(NSW - 1));
    l6_idx++;
  end
  always @(negedge clk) if (w16_valid) begin
    if (w16_idx < NSW) sweep_check("w16", w16_idx, 16, 4, 64'(w16_sum), w16_cout, w16_tag);
    else check_eq("w16_extra", 65'(w16_idx), 65'(NSW - 1));
    w16_idx++;
  end

  // One beat through an otherwise idle pipe; checks latency and result.
  task automatic send_one(input vec_t v);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_cin    = v.cin;
    in_tag    = v.tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq("lat", 65'(lat), 65'(LAT - 1));
    check_eq("tag", 65'(out_tag), 65'(v.tag));
    check_eq("sum", 65'(out_sum), 65'(v.sum));
    check_eq("cout", 65'(out_cout), 65'(v.cout));
    $display("txn tag=%02h sum=%h cout=%0d lat=%0d", out_tag, out_sum, out_cout, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        dv [8];
    vec_t        rv;
    logic [63:0] st_a [NST];
    logic [63:0] st_b [NST];
    logic        st_cin [NST];
    logic [64:0] full;
    logic [63:0] hold_sum;
    bit          hold_v;
    int          k, rcv, t, extra;

    dv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 8'h11, 64'h0, 1'b1};
    dv[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 8'h12, 64'h0, 1'b1};
    dv[2] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 8'h13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    dv[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 8'h14, 64'h0, 1'b1};
    dv[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 8'h15, 64'h2222_2222_2222_2212, 1'b0};
    dv[5] = '{64'h0, 64'h0, 1'b0, 8'h16, 64'h0, 1'b0};
    dv[6] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 8'h17, 64'h0000_0001_0000_0000, 1'b0};
    dv[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h18, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    rv    = '{64'h0000_0000_0000_00FF, 64'h1, 1'b1, 8'h77, 64'h0000_0000_0000_0101, 1'b0};

    rst = 1'b1; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1; sw_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_in_ready", 65'(in_ready), 65'(0));
    check_eq("rst_out_valid", 65'(out_valid), 65'(0));
    check_eq("rst_out_sum", 65'(out_sum), 65'(0));
    check_eq("rst_out_cout", 65'(out_cout), 65'(0));
    check_eq("rst_out_tag", 65'(out_tag), 65'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 65'(in_ready), 65'(1));

    for (int i = 0; i < 8; i++) send_one(dv[i]);

    // Streaming with a 4-cycle consumer stall.
    for (int i = 0; i < NST; i++) begin
      st_a[i]   = {$urandom(), $urandom()};
      st_b[i]   = {$urandom(), $urandom()};
      st_cin[i] = 1'($urandom_range(1, 0));
    end
    k = 0; rcv = 0; t = 0; hold_v = 1'b0; hold_sum = '0;
    while (rcv < NST && t < 200) begin
      @(negedge clk);
      out_ready = !(t >= 6 && t <= 9);
      if (k < NST) begin
        in_valid = 1'b1;
        in_a     = st_a[k];
        in_b     = st_b[k];
        in_cin   = st_cin[k];
        in_tag   = 8'(k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check_eq("st_in_ready", 65'(in_ready), 65'(!(t >= 6 && t <= 9)));
      if (t >= 6 && t <= 9) check_eq("st_stall_valid", 65'(out_valid), 65'(1));
      if (out_valid && !out_ready) begin
        if (hold_v) check_eq("st_hold_sum", 65'(out_sum), 65'(hold_sum));
        hold_sum = out_sum;
        hold_v   = 1'b1;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (rcv < NST) begin
          full = {1'b0, st_a[rcv]} + {1'b0, st_b[rcv]} + 65'(st_cin[rcv]);
          check_eq("st_tag", 65'(out_tag), 65'(8'(rcv)));
          check_eq("st_sum", 65'(out_sum), {1'b0, full[63:0]});
          check_eq("st_cout", 65'(out_cout), 65'(full[64]));
          $display("stream tag=%02h sum=%h cout=%0d", out_tag, out_sum, out_cout);
        end
        rcv++;
      end
      if (in_valid && in_ready) k++;
      t++;
    end
    check_eq("st_count", 65'(rcv), 65'(NST));
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with beats in flight; a beat offered during reset must be dropped.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = {$urandom(), $urandom()};
      in_b     = {$urandom(), $urandom()};
      in_cin   = 1'b0;
      in_tag   = 8'(8'hA0 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("mid_pre_valid", 65'(out_valid), 65'(1));
    rst      = 1'b1;
    in_valid = 1'b1;
    in_tag   = 8'hEE;
    #1;
    check_eq("mid_rst_valid", 65'(out_valid), 65'(0));
    check_eq("mid_rst_sum", 65'(out_sum), 65'(0));
    check_eq("mid_rst_ready", 65'(in_ready), 65'(0));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    send_one(rv);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check_eq("mid_no_stale", 65'(extra), 65'(0));

    // Same stream into the parameter-sweep instances.
    for (int i = 0; i < NSW; i++) begin
      sw_a[i]   = {$urandom(), $urandom()};
      sw_b[i]   = {$urandom(), $urandom()};
      sw_cin[i] = 1'($urandom_range(1, 0));
    end
    for (int i = 0; i < NSW; i++) begin
      @(negedge clk);
      sw_valid  = 1'b1;
      in_a      = sw_a[i];
      in_b      = sw_b[i];
      in_cin    = sw_cin[i];
      in_tag    = 8'(i);
      sw_acc[i] = cyc + 1;
    end
    @(negedge clk);
    sw_valid = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("l1_count", 65'(l1_idx), 65'(NSW));
    check_eq("l3_count", 65'(l3_idx), 65'(NSW));
    check_eq("l6_count", 65'(l6_idx), 65'(NSW));
    check_eq("w16_count", 65'(w16_idx), 65'(NSW));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefix_cpa_pipe.md
Name: prefix_cpa_pipe

Overview:
Pipelined parallel-prefix (Kogge-Stone) carry-propagate adder that consumes the final sum and carry rows produced by the Dadda reduction tree and produces the binary product. Each bit pair is encoded as a 2-bit KPG code: 00 kill, 11 generate, 01/10 propagate. Prefix combining follows the team's operator: if the upper code is 00 or 11 the result is the upper code, otherwise it is the lower code. Prefix levels are register-sliced, and a valid/ready handshake lets the tree front end and the product consumer stall independently.

Parameters:
WIDTH, 64, operand/sum width in bits; power of two, at least 4.
LEVELS_PER_STAGE, 2, prefix levels evaluated combinationally between pipeline registers; 1 to log2(WIDTH).
TAG_W, 8, width of the side-band tag carried alongside each operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands this cycle
in_a  input  WIDTH  sum row from Dadda tree
in_b  input  WIDTH  carry row from Dadda tree
in_cin  input  1  carry-in
in_tag  input  TAG_W  opaque tag, returned with the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH
out_cout  output  1  carry out of bit WIDTH-1
out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset is one clock with an asynchronous, active-high reset. While rst is high, every stage valid bit clears, out_valid=0, out_sum=0, out_cout=0, out_tag=0. in_ready is 0 while rst is asserted and 1 in the first cycle after deassertion.
- Stage count: K = ceil(log2(WIDTH)/LEVELS_PER_STAGE). The pipeline registers are S0 (operands, tag, KPG codes), S1..SK (prefix results after each group of levels), then OUT (sum, cout, tag). Latency LAT = K+2 registers.
- Defaults give K=3 and LAT=5. A beat accepted at clock edge n is presented on the outputs from edge n+4 (n+LAT-1).
- Carry-in is inserted as a code at position -1: 11 if in_cin=1, otherwise 00. Bit i's carry equals the prefix over positions -1..i-1.
- Sum bit i = a[i] XOR b[i] XOR carry_in(i). out_cout is the prefix over -1..WIDTH-1, taken as 1 if the result is 11 and 0 if it is 00. A result code of 01 or 10 after full prefix is impossible and is flagged as an assertion failure in simulation.
- Kogge-Stone levels: at level j (j=0..log2(WIDTH)-1), position i combines with position i-2^j. A position whose partner index falls below -1 passes its code through unchanged.
- Handshake: stall = out_valid AND NOT out_ready, and in_ready = NOT stall. When stall is high, every stage register holds its value, including its valid bit. An input beat is accepted only when in_valid AND in_ready are both high.
- Bubbles: each stage carries a valid bit, and data registers may update freely when their valid bit is 0. The pipeline does not compact bubbles. With no stall, the output order and spacing exactly match the input order and spacing.
- Throughput: 1 result per clock when out_ready is held at 1.
- Outputs are stable while out_valid=1 and out_ready=0; out_sum, out_cout and out_tag must not change.
- When out_valid is 0, out_sum, out_cout and out_tag hold their last values. Only out_valid is meaningful.
- Reset mid-operation: all in-flight beats are discarded and none appears after reset. in_valid asserted during rst is ignored.
- Simultaneous output release and input arrival: when out_ready=1 and in_valid=1 in the same cycle, the output pops and the new beat is accepted on the same edge.

Test Plan:
- Ripple through every bit: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0, tag=0x11 -> sum=0x0, cout=1, tag=0x11. out_valid must rise exactly LAT-1=4 edges after the acceptance edge.
- Carry-in across an all-propagate row: a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 -> sum=0x0, cout=1. Then a=0x5555_5555_5555_5555, b=0xAAAA_AAAA_AAAA_AAAA, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0.
- MSB generate: a=b=0x8000_0000_0000_0000, cin=0 -> sum=0x0, cout=1. Also a=0x1234_5678_9ABC_DEF0, b=0x0FED_CBA9_8765_4321, cin=1 -> sum=0x2222_2222_2222_2212, cout=0.
- Streaming and stall: drive 20 back-to-back random beats with tags 0..19, holding out_ready=0 for cycles 6-9.
  - in_ready must be 0 while out_valid=1 and out_ready=0.
  - Results must match a reference model in tag order, with no loss or duplication.
  - out_sum must stay stable throughout the stall.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 immediately, no stale beat ever emerges, and the first beat accepted after reset returns correctly at LAT-1 edges.
- Parameter sweep: repeat the random stream with LEVELS_PER_STAGE=1, 3 and 6 at WIDTH=64, expecting LAT=8, 4 and 3. Also run WIDTH=16 with defaults, expecting LAT=4. All results must match the model.
